// File: rtl/countdown_timer.sv
// countdown_timer -- mm:ss BCD countdown timer.
//
// Loaded with a start time, decrements once per prescaler tick while running,
// and pulses done for one cycle when the count reaches 00:00. Digit layout
// matches the stopwatch so both can share the same display path.
//
// Parameters:
//   TICK_DIV  clock cycles per one-second tick (>= 1; 1 = decrement every clock)
//   DIV_W     prescaler width, 2**DIV_W >= TICK_DIV
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   load     in   latch ld_* (clamped to legal BCD) as the new start time
//   start    in   begin or resume counting
//   pause    in   halt counting, hold value (wins over start)
//   ld_m1/ld_m2/ld_s1/ld_s2   in   load digits (tens min, min, tens sec, sec)
//   m1/m2/s1/s2               out  current digits
//   running  out  high while in RUN
//   done     out  one-cycle pulse on expiry
//
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN
//   When defined, expiry pulses done but the following edge reloads the digits
//   from the reload register and counting continues (unless that register is
//   00:00, in which case the timer ends in DONE as usual).
module countdown_timer #(
   parameter int TICK_DIV = 1,
   parameter int DIV_W    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [2:0] ld_m1,
   input  logic [3:0] ld_m2,
   input  logic [2:0] ld_s1,
   input  logic [3:0] ld_s2,
   output logic [2:0] m1,
   output logic [3:0] m2,
   output logic [2:0] s1,
   output logic [3:0] s2,
   output logic       running,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

   localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

   state_t           state_q, state_d;
   logic [2:0]       m1_q, m1_d, s1_q, s1_d;
   logic [3:0]       m2_q, m2_d, s2_q, s2_d;
   logic [2:0]       rl_m1_q, rl_m1_d, rl_s1_q, rl_s1_d;
   logic [3:0]       rl_m2_q, rl_m2_d, rl_s2_q, rl_s2_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic             running_q, running_d;
   logic             done_q, done_d;

   // decremented value and borrow chain
   logic [2:0] dec_m1, dec_s1;
   logic [3:0] dec_m2, dec_s2;
   logic       b_s2, b_s1, b_m2;
   logic       dec_zero, cur_zero;
   logic [2:0] cl_m1, cl_s1;
   logic [3:0] cl_m2, cl_s2;

   function automatic logic [3:0] clamp9(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   function automatic logic [2:0] clamp5(input logic [2:0] v);
      return (v > 3'd5) ? 3'd5 : v;
   endfunction

   always_comb begin
      cl_m1 = clamp5(ld_m1);
      cl_m2 = clamp9(ld_m2);
      cl_s1 = clamp5(ld_s1);
      cl_s2 = clamp9(ld_s2);

      b_s2   = (s2_q == 4'd0);
      dec_s2 = b_s2 ? 4'd9 : s2_q - 4'd1;
      b_s1   = b_s2 && (s1_q == 3'd0);
      dec_s1 = b_s2 ? ((s1_q == 3'd0) ? 3'd5 : s1_q - 3'd1) : s1_q;
      b_m2   = b_s1 && (m2_q == 4'd0);
      dec_m2 = b_s1 ? ((m2_q == 4'd0) ? 4'd9 : m2_q - 4'd1) : m2_q;
      dec_m1 = b_m2 ? m1_q - 3'd1 : m1_q;

      dec_zero = (dec_m1 == 3'd0) && (dec_m2 == 4'd0) &&
                 (dec_s1 == 3'd0) && (dec_s2 == 4'd0);
      cur_zero = (m1_q == 3'd0) && (m2_q == 4'd0) &&
                 (s1_q == 3'd0) && (s2_q == 4'd0);
   end

`ifdef COUNTDOWN_AUTORELOAD_EN
   logic rl_zero;
   assign rl_zero = (rl_m1_q == 3'd0) && (rl_m2_q == 4'd0) &&
                    (rl_s1_q == 3'd0) && (rl_s2_q == 4'd0);
`endif

   always_comb begin
      state_d = state_q;
      m1_d    = m1_q;
      m2_d    = m2_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      rl_m1_d = rl_m1_q;
      rl_m2_d = rl_m2_q;
      rl_s1_d = rl_s1_q;
      rl_s2_d = rl_s2_q;
      presc_d = presc_q;
      done_d  = 1'b0;

      if (load) begin
         m1_d    = cl_m1;
         m2_d    = cl_m2;
         s1_d    = cl_s1;
         s2_d    = cl_s2;
         rl_m1_d = cl_m1;
         rl_m2_d = cl_m2;
         rl_s1_d = cl_s1;
         rl_s2_d = cl_s2;
         presc_d = '0;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, PAUSED: begin
               // pause beats start; starting from 00:00 expires immediately
               if (start && !pause) begin
                  if (cur_zero) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               if (pause) begin
                  state_d = PAUSED;
`ifdef COUNTDOWN_AUTORELOAD_EN
               end else if (cur_zero) begin
                  // 00:00 shown for one cycle after expiry, now restart
                  m1_d    = rl_m1_q;
                  m2_d    = rl_m2_q;
                  s1_d    = rl_s1_q;
                  s2_d    = rl_s2_q;
                  presc_d = '0;
`endif
               end else if (presc_q == TICK_LAST) begin
                  presc_d = '0;
                  m1_d    = dec_m1;
                  m2_d    = dec_m2;
                  s1_d    = dec_s1;
                  s2_d    = dec_s2;
                  if (dec_zero) begin
                     done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     if (rl_zero) state_d = DONE;
`else
                     state_d = DONE;
`endif
                  end
               end else begin
                  presc_d = presc_q + DIV_W'(1);
               end
            end
            default: ; // DONE holds 00:00 until load
         endcase
      end

      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         m1_q      <= '0;
         m2_q      <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         rl_m1_q   <= '0;
         rl_m2_q   <= '0;
         rl_s1_q   <= '0;
         rl_s2_q   <= '0;
         presc_q   <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m1_q      <= m1_d;
         m2_q      <= m2_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         rl_m1_q   <= rl_m1_d;
         rl_m2_q   <= rl_m2_d;
         rl_s1_q   <= rl_s1_d;
         rl_s2_q   <= rl_s2_d;
         presc_q   <= presc_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign m1      = m1_q;
   assign m2      = m2_q;
   assign s1      = s1_q;
   assign s2      = s2_q;
   assign running = running_q;
   assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: two instances (TICK_DIV=1 and TICK_DIV=4).
// The driver issues one directed vector per cycle and queues the expected
// outputs after that edge; a monitor pops and compares on the falling edge.
module tb_countdown_timer;

   typedef struct {
      logic [15:0] dig;   // {0,m1,m2,0,s1,s2}
      logic        run;
      logic        dn;
      int          step;
   } exp_t;

   localparam logic [3:0] NOP = 4'b0000;
   localparam logic [3:0] ST  = 4'b0001;
   localparam logic [3:0] PS  = 4'b0010;
   localparam logic [3:0] LD  = 4'b0100;
   localparam logic [3:0] RS  = 4'b1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, load_a = 1'b0, start_a = 1'b0, pause_a = 1'b0;
   logic [2:0] ldm1_a = '0, lds1_a = '0;
   logic [3:0] ldm2_a = '0, lds2_a = '0;
   logic [2:0] m1_a, s1_a;
   logic [3:0] m2_a, s2_a;
   logic       run_a, done_a;

   logic       rst_b = 1'b1, load_b = 1'b0, start_b = 1'b0, pause_b = 1'b0;
   logic [2:0] ldm1_b = '0, lds1_b = '0;
   logic [3:0] ldm2_b = '0, lds2_b = '0;
   logic [2:0] m1_b, s1_b;
   logic [3:0] m2_b, s2_b;
   logic       run_b, done_b;

   countdown_timer #(.TICK_DIV(1), .DIV_W(16)) u_a (
      .clk(clk), .reset(rst_a), .load(load_a), .start(start_a), .pause(pause_a),
      .ld_m1(ldm1_a), .ld_m2(ldm2_a), .ld_s1(lds1_a), .ld_s2(lds2_a),
      .m1(m1_a), .m2(m2_a), .s1(s1_a), .s2(s2_a),
      .running(run_a), .done(done_a)
   );

   countdown_timer #(.TICK_DIV(4), .DIV_W(16)) u_b (
      .clk(clk), .reset(rst_b), .load(load_b), .start(start_b), .pause(pause_b),
      .ld_m1(ldm1_b), .ld_m2(ldm2_b), .ld_s1(lds1_b), .ld_s2(lds2_b),
      .m1(m1_b), .m2(m2_b), .s1(s1_b), .s2(s2_b),
      .running(run_b), .done(done_b)
   );

   exp_t qa[$];
   exp_t qb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   step_no    = 0;

   // monitor: one expected record per cycle per instance
   always @(negedge clk) begin
      logic [15:0] act;
      exp_t        e;
      if (qa.size() > 0) begin
         e   = qa.pop_front();
         act = {1'b0, m1_a, m2_a, 1'b0, s1_a, s2_a};
         compared++;
         if (act !== e.dig || run_a !== e.run || done_a !== e.dn) begin
            mismatched++;
            $display("FAIL tdiv1 step %0d: got %h run=%b done=%b, expected %h run=%b done=%b",
                     e.step, act, run_a, done_a, e.dig, e.run, e.dn);
         end
      end
      if (qb.size() > 0) begin
         e   = qb.pop_front();
         act = {1'b0, m1_b, m2_b, 1'b0, s1_b, s2_b};
         compared++;
         if (act !== e.dig || run_b !== e.run || done_b !== e.dn) begin
            mismatched++;
            $display("FAIL tdiv4 step %0d: got %h run=%b done=%b, expected %h run=%b done=%b",
                     e.step, act, run_b, done_b, e.dig, e.run, e.dn);
         end
      end
   end

   // one clock of stimulus to instance sel (0=A,1=B); the other gets no controls
   task automatic cyc(input bit sel, input logic [3:0] ctl, input logic [15:0] ldv,
                      input logic [15:0] ed, input logic er, input logic edn);
      exp_t e;
      @(negedge clk);
      #1;
      step_no++;
      e.dig = ed; e.run = er; e.dn = edn; e.step = step_no;
      {rst_a, load_a, pause_a, start_a} = sel ? NOP : ctl;
      {rst_b, load_b, pause_b, start_b} = sel ? ctl : NOP;
      ldm1_a = ldv[14:12]; ldm2_a = ldv[11:8]; lds1_a = ldv[6:4]; lds2_a = ldv[3:0];
      ldm1_b = ldv[14:12]; ldm2_b = ldv[11:8]; lds1_b = ldv[6:4]; lds2_b = ldv[3:0];
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
   endtask

   initial begin
      // ---------------- instance A, TICK_DIV=1 ----------------
      cyc(0, RS, 16'h0000, 16'h0000, 0, 0);
      cyc(0, RS, 16'h0000, 16'h0000, 0, 0);
`ifndef COUNTDOWN_AUTORELOAD_EN
      cyc(0, LD,  16'h0003, 16'h0003, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0003, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0002, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0001, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0000, 0, 1);
      cyc(0, NOP, 16'h0000, 16'h0000, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0000, 0, 0);   // start ignored in DONE
      // 10:00 -> 09:59
      cyc(0, LD,  16'h1000, 16'h1000, 0, 0);
      cyc(0, ST,  16'h0000, 16'h1000, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0959, 1, 0);
      cyc(0, PS,  16'h0000, 16'h0959, 0, 0);
      // 01:00 -> 00:59, then load while running
      cyc(0, LD,  16'h0100, 16'h0100, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0100, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0059, 1, 0);
      cyc(0, LD,  16'h0010, 16'h0010, 0, 0);
      // pause / resume
      cyc(0, ST,  16'h0000, 16'h0010, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0009, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0008, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0007, 1, 0);
      cyc(0, PS,  16'h0000, 16'h0007, 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, NOP, 16'h0000, 16'h0007, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0007, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0006, 1, 0);
      cyc(0, PS,  16'h0000, 16'h0006, 0, 0);
      cyc(0, PS | ST, 16'h0000, 16'h0006, 0, 0);
      cyc(0, NOP, 16'h0000, 16'h0006, 0, 0);
      // clamping: m1=6, m2=12, s1=7, s2=15 -> 59:59
      cyc(0, LD,  16'h6C7F, 16'h5959, 0, 0);
      cyc(0, ST,  16'h0000, 16'h5959, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h5958, 1, 0);
      // start at 00:00
      cyc(0, LD,  16'h0000, 16'h0000, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0000, 0, 1);
      cyc(0, NOP, 16'h0000, 16'h0000, 0, 0);
      // reset mid-run
      cyc(0, LD,  16'h0008, 16'h0008, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0008, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0007, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0006, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0005, 1, 0);
      cyc(0, RS,  16'h0000, 16'h0000, 0, 0);
      cyc(0, NOP, 16'h0000, 16'h0000, 0, 0);
      // leave DONE only via load
      cyc(0, LD,  16'h0002, 16'h0002, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0002, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0001, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0000, 0, 1);
      cyc(0, ST,  16'h0000, 16'h0000, 0, 0);
      cyc(0, LD,  16'h0002, 16'h0002, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0002, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0001, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0000, 0, 1);
      cyc(0, NOP, 16'h0000, 16'h0000, 0, 0);
      // load beats start; s1 borrow
      cyc(0, LD | ST, 16'h0030, 16'h0030, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0030, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0029, 1, 0);
`else
      cyc(0, LD,  16'h0002, 16'h0002, 0, 0);
      cyc(0, ST,  16'h0000, 16'h0002, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0001, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0000, 1, 1);
      cyc(0, NOP, 16'h0000, 16'h0002, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0001, 1, 0);
      cyc(0, NOP, 16'h0000, 16'h0000, 1, 1);
      cyc(0, NOP, 16'h0000, 16'h0002, 1, 0);
      cyc(0, PS,  16'h0000, 16'h0002, 0, 0);
`endif
      // ---------------- instance B, TICK_DIV=4 ----------------
      cyc(1, RS,  16'h0000, 16'h0000, 0, 0);
      cyc(1, RS,  16'h0000, 16'h0000, 0, 0);
      cyc(1, LD,  16'h0002, 16'h0002, 0, 0);
      cyc(1, ST,  16'h0000, 16'h0002, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, NOP, 16'h0000, 16'h0002, 1, 0);
      cyc(1, NOP, 16'h0000, 16'h0001, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, NOP, 16'h0000, 16'h0001, 1, 0);
`ifdef COUNTDOWN_AUTORELOAD_EN
      cyc(1, NOP, 16'h0000, 16'h0000, 1, 1);
      cyc(1, NOP, 16'h0000, 16'h0002, 1, 0);
      cyc(1, LD,  16'h0000, 16'h0000, 0, 0);
`else
      cyc(1, NOP, 16'h0000, 16'h0000, 0, 1);
      cyc(1, NOP, 16'h0000, 16'h0000, 0, 0);
`endif
      @(negedge clk);
      #1;
      compared++;
      if (qa.size() != 0 || qb.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d/%0d records left unchecked, expected 0/0", qa.size(), qb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
